// File: rtl/cnn_run_ctrl.sv
// cnn_run_ctrl: debounces the start switch and runs one cnn_top inference per press under a timeout watchdog.
//   clk, reset (async, active-high), start_sw (raw switch)
//   cnn_start/cnn_finish/cnn_class : handshake with cnn_top
//   result_class, result_valid, busy, timeout_err, run_count : status for LEDs and hex display
module cnn_run_ctrl #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int TIMEOUT_CYCLES  = 16777216,
  parameter int CLASS_W         = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               start_sw,
  output logic               cnn_start,
  input  logic               cnn_finish,
  input  logic [CLASS_W-1:0] cnn_class,
  output logic [CLASS_W-1:0] result_class,
  output logic               result_valid,
  output logic               busy,
  output logic               timeout_err,
  output logic [7:0]         run_count
);
  localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;
  state_t state;
  logic s1, s2, level, level_q, press;
  logic [DW-1:0] dcnt;
  logic [TW-1:0] tcnt;
  // a new level is accepted only after it has been stable long enough in the synchronized domain
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1      <= 1'b0;
      s2      <= 1'b0;
      level   <= 1'b0;
      level_q <= 1'b0;
      dcnt    <= '0;
    end else begin
      s1      <= start_sw;
      s2      <= s1;
      level_q <= level;
      if (s2 == level) dcnt <= '0;
      else if (dcnt == DW'(DEBOUNCE_CYCLES - 1)) begin
        level <= s2;
        dcnt  <= '0;
      end else dcnt <= dcnt + 1'b1;
    end
  end
  assign press = level & ~level_q;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state        <= IDLE;
      tcnt         <= '0;
      cnn_start    <= 1'b0;
      busy         <= 1'b0;
      result_class <= '0;
      result_valid <= 1'b0;
      timeout_err  <= 1'b0;
      run_count    <= '0;
    end else begin
      case (state)
        IDLE: if (press) begin
          result_valid <= 1'b0;
          timeout_err  <= 1'b0;
          tcnt         <= '0;
          cnn_start    <= 1'b1;
          busy         <= 1'b1;
          state        <= RUN;
        end
        RUN: begin
          tcnt <= tcnt + 1'b1;
          // finish takes priority over a timeout landing in the same cycle
          if (cnn_finish) begin
            result_class <= cnn_class;
            result_valid <= 1'b1;
            run_count    <= &run_count ? run_count : run_count + 1'b1;
            cnn_start    <= 1'b0;
            state        <= DRAIN;
          end else if (tcnt == TW'(TIMEOUT_CYCLES - 1)) begin
            timeout_err <= 1'b1;
            cnn_start   <= 1'b0;
            state       <= DRAIN;
          end
        end
        DRAIN: if (!cnn_finish) begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cnn_run_ctrl.sv
// tb_cnn_run_ctrl: directed self-checking bench for cnn_run_ctrl with DEBOUNCE_CYCLES=4, TIMEOUT_CYCLES=64.
module tb_cnn_run_ctrl;
  logic clk = 1'b0, reset = 1'b1, start_sw = 1'b0, cnn_finish = 1'b0;
  logic [3:0] cnn_class = '0;
  logic cnn_start, result_valid, busy, timeout_err;
  logic [3:0] result_class;
  logic [7:0] run_count;
  int checks = 0, failures = 0;

  cnn_run_ctrl #(.DEBOUNCE_CYCLES(4), .TIMEOUT_CYCLES(64), .CLASS_W(4)) dut (
    .clk(clk), .reset(reset), .start_sw(start_sw), .cnn_start(cnn_start),
    .cnn_finish(cnn_finish), .cnn_class(cnn_class), .result_class(result_class),
    .result_valid(result_valid), .busy(busy), .timeout_err(timeout_err), .run_count(run_count)
  );

  always #5 clk = ~clk;

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic apply_reset;
    reset = 1'b1; start_sw = 1'b0; cnn_finish = 1'b0; cnn_class = '0;
    cyc(2);
    reset = 1'b0;
  endtask

  // press lands in RUN 7 edges after start_sw rises; the switch is back to a stable low by the end
  task automatic do_press;
    start_sw = 1'b1; cyc(8);
    start_sw = 1'b0; cyc(8);
  endtask

  task automatic finish_run(input logic [3:0] c);
    cnn_class = c; cnn_finish = 1'b1; cyc(1);
    cnn_finish = 1'b0; cyc(1);
  endtask

  task automatic test_reset;
    reset = 1'b1; cyc(2);
    checks++; if ({cnn_start, busy, result_valid, timeout_err} !== 4'b0) begin failures++; $display("FAIL reset_flags got=%b want=0000", {cnn_start, busy, result_valid, timeout_err}); end
    checks++; if (run_count !== 8'd0) begin failures++; $display("FAIL reset_run_count got=%0d want=0", run_count); end
    checks++; if (result_class !== 4'd0) begin failures++; $display("FAIL reset_class got=%0d want=0", result_class); end
  endtask

  task automatic test_basic;
    apply_reset;
    start_sw = 1'b1; cyc(6);
    checks++; if (cnn_start !== 1'b0) begin failures++; $display("FAIL basic_pre_start got=%b want=0", cnn_start); end
    cyc(1);
    checks++; if ({cnn_start, busy} !== 2'b11) begin failures++; $display("FAIL basic_start got=%b want=11", {cnn_start, busy}); end
    cyc(3); start_sw = 1'b0; cyc(17);
    cnn_class = 4'd7; cnn_finish = 1'b1; cyc(1);
    checks++; if ({result_class, result_valid, cnn_start, busy} !== {4'd7, 3'b101}) begin failures++; $display("FAIL basic_finish got class=%0d valid=%b start=%b busy=%b want 7 1 0 1", result_class, result_valid, cnn_start, busy); end
    checks++; if (run_count !== 8'd1) begin failures++; $display("FAIL basic_count got=%0d want=1", run_count); end
    cnn_finish = 1'b0; cnn_class = 4'd2; cyc(1);
    checks++; if ({busy, result_class} !== {1'b0, 4'd7}) begin failures++; $display("FAIL basic_idle got busy=%b class=%0d want 0 7", busy, result_class); end
  endtask

  task automatic test_bounce;
    logic seen;
    apply_reset;
    seen = 1'b0;
    for (int i = 0; i < 10; i++) begin
      start_sw = ~start_sw;
      for (int k = 0; k < 2; k++) begin cyc(1); seen |= cnn_start; end
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL bounce_no_early_run got=%b want=0", seen); end
    start_sw = 1'b1; cyc(8); start_sw = 1'b0; cyc(8);
    checks++; if (cnn_start !== 1'b1) begin failures++; $display("FAIL bounce_run got=%b want=1", cnn_start); end
    finish_run(4'd4); cyc(10);
    checks++; if (run_count !== 8'd1) begin failures++; $display("FAIL bounce_count got=%0d want=1", run_count); end
    seen = 1'b0;
    for (int i = 0; i < 4; i++) begin
      start_sw = 1'b1;
      for (int k = 0; k < 3; k++) begin cyc(1); seen |= cnn_start; end
      start_sw = 1'b0;
      for (int k = 0; k < 6; k++) begin cyc(1); seen |= cnn_start; end
    end
    checks++; if (seen !== 1'b0) begin failures++; $display("FAIL glitch_no_press got=%b want=0", seen); end
  endtask

  task automatic test_timeout;
    apply_reset;
    start_sw = 1'b1; cyc(7); start_sw = 1'b0; cyc(63);
    checks++; if ({cnn_start, timeout_err} !== 2'b10) begin failures++; $display("FAIL timeout_early got start=%b err=%b want 1 0", cnn_start, timeout_err); end
    cyc(1);
    checks++; if ({timeout_err, cnn_start, result_valid, busy} !== 4'b1001) begin failures++; $display("FAIL timeout_fire got err=%b start=%b valid=%b busy=%b want 1 0 0 1", timeout_err, cnn_start, result_valid, busy); end
    checks++; if (run_count !== 8'd0) begin failures++; $display("FAIL timeout_count got=%0d want=0", run_count); end
    cyc(1);
    checks++; if ({busy, timeout_err} !== 2'b01) begin failures++; $display("FAIL timeout_hold got busy=%b err=%b want 0 1", busy, timeout_err); end
    do_press;
    checks++; if ({timeout_err, cnn_start} !== 2'b01) begin failures++; $display("FAIL timeout_clear got err=%b start=%b want 0 1", timeout_err, cnn_start); end
    finish_run(4'd3);
    checks++; if ({result_class, run_count} !== {4'd3, 8'd1}) begin failures++; $display("FAIL timeout_recover got class=%0d count=%0d want 3 1", result_class, run_count); end
  endtask

  task automatic test_busy_and_tie;
    apply_reset;
    start_sw = 1'b1; cyc(7); start_sw = 1'b0; cyc(10);
    start_sw = 1'b1; cyc(10); start_sw = 1'b0; cyc(43);
    checks++; if ({cnn_start, timeout_err} !== 2'b10) begin failures++; $display("FAIL tie_pre got start=%b err=%b want 1 0", cnn_start, timeout_err); end
    cnn_class = 4'd9; cnn_finish = 1'b1; cyc(1);
    checks++; if ({result_valid, timeout_err, result_class} !== {2'b10, 4'd9}) begin failures++; $display("FAIL tie_finish_wins got valid=%b err=%b class=%0d want 1 0 9", result_valid, timeout_err, result_class); end
    cnn_finish = 1'b0; cyc(1);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL tie_idle got busy=%b want 0", busy); end
    cyc(20);
    checks++; if ({cnn_start, run_count} !== {1'b0, 8'd1}) begin failures++; $display("FAIL busy_press_ignored got start=%b count=%0d want 0 1", cnn_start, run_count); end
  endtask

  task automatic test_saturation_stuck;
    apply_reset;
    for (int i = 0; i < 256; i++) begin
      do_press;
      finish_run(4'(i));
    end
    checks++; if ({run_count, result_class} !== {8'd255, 4'd15}) begin failures++; $display("FAIL sat_256 got count=%0d class=%0d want 255 15", run_count, result_class); end
    do_press;
    cnn_class = 4'd5; cnn_finish = 1'b1; cyc(1);
    checks++; if ({run_count, result_class} !== {8'd255, 4'd5}) begin failures++; $display("FAIL sat_hold got count=%0d class=%0d want 255 5", run_count, result_class); end
    cyc(5);
    checks++; if ({busy, cnn_start} !== 2'b10) begin failures++; $display("FAIL stuck_drain got busy=%b start=%b want 1 0", busy, cnn_start); end
    start_sw = 1'b1; cyc(8); start_sw = 1'b0; cyc(8);
    checks++; if ({busy, cnn_start} !== 2'b10) begin failures++; $display("FAIL stuck_press got busy=%b start=%b want 1 0", busy, cnn_start); end
    cnn_finish = 1'b0; cyc(1);
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL stuck_release got busy=%b want 0", busy); end
    cyc(10);
    checks++; if (cnn_start !== 1'b0) begin failures++; $display("FAIL stuck_press_dropped got=%b want 0", cnn_start); end
  endtask

  task automatic test_async_reset;
    apply_reset;
    do_press;
    finish_run(4'd6);
    start_sw = 1'b1; cyc(7);
    checks++; if ({cnn_start, busy, run_count} !== {2'b11, 8'd1}) begin failures++; $display("FAIL areset_pre got start=%b busy=%b count=%0d want 1 1 1", cnn_start, busy, run_count); end
    #2 reset = 1'b1; start_sw = 1'b0;
    #1;
    checks++; if ({cnn_start, busy, result_valid, timeout_err} !== 4'b0) begin failures++; $display("FAIL areset_flags got=%b want 0000", {cnn_start, busy, result_valid, timeout_err}); end
    checks++; if ({run_count, result_class} !== 12'd0) begin failures++; $display("FAIL areset_data got count=%0d class=%0d want 0 0", run_count, result_class); end
    @(negedge clk); reset = 1'b0; cyc(20);
    checks++; if ({cnn_start, busy} !== 2'b00) begin failures++; $display("FAIL areset_no_run got start=%b busy=%b want 0 0", cnn_start, busy); end
  endtask

  initial begin
    test_reset;
    test_basic;
    test_bounce;
    test_timeout;
    test_busy_and_tie;
    test_saturation_stuck;
    test_async_reset;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
